// File: rtl/hybrid_sub8_seq_if.sv
// hybrid_sub8_seq_if: request/result bundle for the segmented 8-bit subtractor
interface hybrid_sub8_seq_if;
  logic       start;
  logic [7:0] s_in;
  logic       c8_in;
  logic [7:0] y_in;
  logic       c0_in;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic       err;
  modport master (output start, s_in, c8_in, y_in, c0_in, input busy, done, x_out, err);
  modport slave (input start, s_in, c8_in, y_in, c0_in, output busy, done, x_out, err);
endinterface

// File: rtl/hybrid_sub8_seq.sv
// hybrid_sub8_seq: recovers X = {C8,S} - Y - C0 one segment (2/4/2 bits) per cycle and flags impossible results
module hybrid_sub8_seq (
  input logic clk,
  input logic rst,
  hybrid_sub8_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LO, MID, HI, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] s_q, s_d, y_q, y_d, diff_q, diff_d, x_q, x_d;
  logic c8_q, c8_d, c0_q, c0_d, b_q, b_d, err_q, err_d;
  logic [7:0] g, p;
  logic b1, b2, b3, b4, b5, b6, b7, b8;
  assign g = ~s_q & y_q;
  assign p = ~(s_q ^ y_q);
  assign b1 = g[0] | (p[0] & c0_q);
  assign b2 = g[1] | (p[1] & b1);
  assign b3 = g[2] | (p[2] & b_q);
  assign b4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & b_q);
  assign b5 = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & b_q);
  assign b6 = g[5] | (p[5] & g[4]) | (p[5] & p[4] & g[3]) | (p[5] & p[4] & p[3] & g[2])
            | (p[5] & p[4] & p[3] & p[2] & b_q);
  assign b7 = g[6] | (p[6] & b_q);
  assign b8 = g[7] | (p[7] & b7);
  assign bus.busy  = (state_q == LO) || (state_q == MID) || (state_q == HI);
  assign bus.done  = state_q == DONE;
  assign bus.x_out = x_q;
  assign bus.err   = err_q;
  // next state: operand capture, one segment per busy cycle, result publish on HI
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    y_d = y_q;
    c8_d = c8_q;
    c0_d = c0_q;
    b_d = b_q;
    diff_d = diff_q;
    x_d = x_q;
    err_d = err_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = bus.start ? LO : IDLE;
        if (bus.start) begin
          s_d = bus.s_in;
          y_d = bus.y_in;
          c8_d = bus.c8_in;
          c0_d = bus.c0_in;
        end
      end
      LO: begin
        diff_d[1:0] = s_q[1:0] ^ y_q[1:0] ^ {b1, c0_q};
        b_d = b2;
        state_d = MID;
      end
      MID: begin
        diff_d[5:2] = s_q[5:2] ^ y_q[5:2] ^ {b5, b4, b3, b_q};
        b_d = b6;
        state_d = HI;
      end
      HI: begin
        x_d = {s_q[7:6] ^ y_q[7:6] ^ {b7, b_q}, diff_q[5:0]};
        err_d = c8_q ^ b8;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      y_q <= '0;
      c8_q <= 1'b0;
      c0_q <= 1'b0;
      b_q <= 1'b0;
      diff_q <= '0;
      x_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      y_q <= y_d;
      c8_q <= c8_d;
      c0_q <= c0_d;
      b_q <= b_d;
      diff_q <= diff_d;
      x_q <= x_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_hybrid_sub8_seq.sv
// tb_hybrid_sub8_seq: directed vectors with hand-computed results for hybrid_sub8_seq
module tb_hybrid_sub8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  hybrid_sub8_seq_if bus ();
  hybrid_sub8_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [7:0] s, input logic c8, input logic [7:0] y, input logic c0);
    bus.start = 1'b1;
    bus.s_in = s;
    bus.c8_in = c8;
    bus.y_in = y;
    bus.c0_in = c0;
  endtask
  task automatic scramble();
    bus.s_in = 8'h5A;
    bus.c8_in = 1'b1;
    bus.y_in = 8'hA5;
    bus.c0_in = 1'b1;
  endtask
  task automatic do_op(input string tag, input logic [7:0] s, input logic c8, input logic [7:0] y,
                       input logic c0, input logic [7:0] ex, input logic ee);
    drive(s, c8, y, c0);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    chk({tag, "_busy_lo"}, {8'h0, bus.busy}, 9'h1);
    chk({tag, "_done_lo"}, {8'h0, bus.done}, 9'h0);
    @(negedge clk);
    chk({tag, "_busy_mid"}, {8'h0, bus.busy}, 9'h1);
    @(negedge clk);
    chk({tag, "_busy_hi"}, {8'h0, bus.busy}, 9'h1);
    chk({tag, "_done_hi"}, {8'h0, bus.done}, 9'h0);
    @(negedge clk);
    chk({tag, "_done"}, {8'h0, bus.done}, 9'h1);
    chk({tag, "_busy_done"}, {8'h0, bus.busy}, 9'h0);
    chk({tag, "_x"}, {1'b0, bus.x_out}, {1'b0, ex});
    chk({tag, "_err"}, {8'h0, bus.err}, {8'h0, ee});
  endtask
  initial begin
    bus.start = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {8'h0, bus.busy}, 9'h0);
    chk("rst_done", {8'h0, bus.done}, 9'h0);
    chk("rst_x", {1'b0, bus.x_out}, 9'h0);
    chk("rst_err", {8'h0, bus.err}, 9'h0);
    do_op("t1", 8'hFD, 1'b1, 8'hFE, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    chk("t1_idle_done", {8'h0, bus.done}, 9'h0);
    chk("t1_hold_x", {1'b0, bus.x_out}, 9'h0FF);
    do_op("aa", 8'hFF, 1'b0, 8'h55, 1'b0, 8'hAA, 1'b0);
    do_op("b2b", 8'h8A, 1'b0, 8'h81, 1'b1, 8'h08, 1'b0);
    do_op("neg", 8'h00, 1'b0, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("ovf", 8'h78, 1'b1, 8'h00, 1'b0, 8'h78, 1'b1);
    do_op("chain", 8'h00, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    chk("chain_idle", {8'h0, bus.busy | bus.done}, 9'h0);
    drive(8'h40, 1'b0, 8'h10, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("ign_done_hi", {8'h0, bus.done}, 9'h0);
    @(negedge clk);
    chk("ign_done", {8'h0, bus.done}, 9'h1);
    chk("ign_x", {1'b0, bus.x_out}, 9'h02F);
    chk("ign_err", {8'h0, bus.err}, 9'h0);
    repeat (4) begin
      @(negedge clk);
      chk("ign_no_second", {8'h0, bus.busy | bus.done}, 9'h0);
    end
    drive(8'h10, 1'b0, 8'h01, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {8'h0, bus.busy}, 9'h0);
    chk("mrst_done", {8'h0, bus.done}, 9'h0);
    chk("mrst_x", {1'b0, bus.x_out}, 9'h0);
    chk("mrst_err", {8'h0, bus.err}, 9'h0);
    repeat (3) begin
      @(negedge clk);
      chk("mrst_no_done", {8'h0, bus.done}, 9'h0);
    end
    do_op("post", 8'h33, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
